// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one memory line port between I-cache and D-cache.
// Memory command and response steering follow the granted requester combinationally.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_d_q, last_d_d;
  logic   i_pend, d_pend;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    case (state_q)
      IDLE: begin
        if (i_pend && d_pend) begin
          state_d  = last_d_q ? SERVE_I : SERVE_D;
          last_d_d = ~last_d_q;
        end else if (d_pend) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
        end else if (i_pend) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
        end
      end
      // On completion the grant passes straight to a waiting peer.
      SERVE_I: begin
        if (mem_resp) begin
          if (d_pend) begin
            state_d  = SERVE_D;
            last_d_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          if (i_pend) begin
            state_d  = SERVE_I;
            last_d_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (state_q)
      SERVE_I: begin
        mem_read    = i_read;
        mem_address = i_address;
        i_resp      = mem_resp;
      end
      SERVE_D: begin
        mem_read    = d_read;
        mem_write   = d_write;
        mem_address = d_address;
        mem_wdata   = d_wdata;
        d_resp      = mem_resp;
      end
      default: ;
    endcase
  end

endmodule
